// File: rtl/tx_hex_display_scanner_pkg.sv
// Shared types and constants for the TX hex display scanner: scan FSM states,
// digit slot indices and the all-digits-off enable pattern.
package tx_disp_pkg;

  typedef enum logic {
    ST_BLANK = 1'b0,
    ST_SCAN  = 1'b1
  } scan_state_t;

  localparam logic [1:0] DIG_LB_LO  = 2'd0;
  localparam logic [1:0] DIG_LB_HI  = 2'd1;
  localparam logic [1:0] DIG_CNT_LO = 2'd2;
  localparam logic [1:0] DIG_CNT_HI = 2'd3;

  localparam logic [3:0] EN_OFF = 4'b1111;

  // Active-low enable pattern that lights only the digit at idx.
  function automatic logic [3:0] digit_on_n(input logic [1:0] idx);
    logic [3:0] one;
    one = 4'b0001;
    return ~(one << idx);
  endfunction

endpackage

// File: rtl/tx_hex_display_scanner_if.sv
// Byte-capture inputs and display outputs of the scanner, plus scan FSM
// debug visibility (current state and digit index).
interface tx_hex_display_scanner_if;
  import tx_disp_pkg::*;

  // byte_valid is a single-cycle strobe with no back-pressure: the byte on
  // byte_in is taken on every rising edge where byte_valid is high.
  logic        byte_valid;
  logic [7:0]  byte_in;
  logic        cnt_clr;
  logic [3:0]  nibble_out;
  logic [3:0]  digit_en_n;
  logic [7:0]  byte_cnt;
  scan_state_t dbg_state;
  logic [1:0]  dbg_digit_idx;

  modport master (
    output byte_valid, byte_in, cnt_clr,
    input  nibble_out, digit_en_n, byte_cnt, dbg_state, dbg_digit_idx
  );

  modport slave (
    input  byte_valid, byte_in, cnt_clr,
    output nibble_out, digit_en_n, byte_cnt, dbg_state, dbg_digit_idx
  );

endinterface

// File: rtl/tx_hex_display_scanner_byte_tracker.sv
// Holds the last transmitted byte and a wrapping 8-bit count of bytes sent.
// A clear in the same cycle as a strobe zeroes the count but still captures the byte.
module tx_byte_tracker (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_byte_valid,
  input  logic [7:0] i_byte_in,
  input  logic       i_cnt_clr,
  output logic [7:0] o_last_byte,
  output logic [7:0] o_byte_cnt
);

  logic [7:0] r_last_byte;
  logic [7:0] r_byte_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_last_byte <= 8'h00;
      r_byte_cnt  <= 8'h00;
    end else begin
      if (i_byte_valid) begin
        r_last_byte <= i_byte_in;
      end
      if (i_cnt_clr) begin
        r_byte_cnt <= 8'h00;
      end else if (i_byte_valid) begin
        r_byte_cnt <= r_byte_cnt + 8'h01;
      end
    end
  end

  assign o_last_byte = r_last_byte;
  assign o_byte_cnt  = r_byte_cnt;

endmodule

// File: rtl/tx_hex_display_scanner.sv
// Four-digit hex scanner (last byte, then byte count) with a blanking gap
// between digit slots. Optional macro TX_DISP_LZB_EN blanks a zero count MSD.
module tx_hex_display_scanner
  import tx_disp_pkg::*;
#(
  parameter int REFRESH_DIV  = 50000,
  parameter int BLANK_CYCLES = 16
) (
  input logic                     clk,
  input logic                     rst,
  tx_hex_display_scanner_if.slave bus
);

  localparam int TMAX = (REFRESH_DIV > BLANK_CYCLES) ? REFRESH_DIV : BLANK_CYCLES;
  localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;
  localparam logic [TW-1:0] T_SCAN_END  = TW'(REFRESH_DIV - 1);
  localparam logic [TW-1:0] T_BLANK_END = TW'(BLANK_CYCLES - 1);

  logic [7:0]  w_last_byte;
  logic [7:0]  w_byte_cnt;

  scan_state_t r_state;
  scan_state_t w_state_nxt;
  logic [TW-1:0] r_timer;
  logic [TW-1:0] w_timer_nxt;
  logic [1:0]  r_idx;
  logic [1:0]  w_idx_nxt;
  logic [3:0]  r_nibble;
  logic [3:0]  w_nibble_nxt;
  logic [3:0]  r_en_n;
  logic [3:0]  w_en_n_nxt;
  logic        w_timer_done;
  logic [3:0]  w_sel_nibble;
  logic        w_lz_blank;

  tx_byte_tracker u_tracker (
    .clk          (clk),
    .rst          (rst),
    .i_byte_valid (bus.byte_valid),
    .i_byte_in    (bus.byte_in),
    .i_cnt_clr    (bus.cnt_clr),
    .o_last_byte  (w_last_byte),
    .o_byte_cnt   (w_byte_cnt)
  );

  assign w_timer_done = (r_state == ST_BLANK) ? (r_timer == T_BLANK_END)
                                              : (r_timer == T_SCAN_END);

  always_comb begin
    w_sel_nibble = 4'h0;
    case (r_idx)
      DIG_LB_LO:  w_sel_nibble = w_last_byte[3:0];
      DIG_LB_HI:  w_sel_nibble = w_last_byte[7:4];
      DIG_CNT_LO: w_sel_nibble = w_byte_cnt[3:0];
      DIG_CNT_HI: w_sel_nibble = w_byte_cnt[7:4];
      default:    w_sel_nibble = 4'h0;
    endcase
  end

`ifdef TX_DISP_LZB_EN
  // Decided from the live count at the slot's load edge; the slot still runs full length.
  assign w_lz_blank = (r_idx == DIG_CNT_HI) && (w_byte_cnt[7:4] == 4'h0);
`else
  assign w_lz_blank = 1'b0;
`endif

  // State register: FSM state plus all registered scan outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= ST_BLANK;
      r_timer  <= '0;
      r_idx    <= DIG_LB_LO;
      r_nibble <= 4'h0;
      r_en_n   <= EN_OFF;
    end else begin
      r_state  <= w_state_nxt;
      r_timer  <= w_timer_nxt;
      r_idx    <= w_idx_nxt;
      r_nibble <= w_nibble_nxt;
      r_en_n   <= w_en_n_nxt;
    end
  end

  // Next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_BLANK: if (w_timer_done) w_state_nxt = ST_SCAN;
      ST_SCAN:  if (w_timer_done) w_state_nxt = ST_BLANK;
      default:  w_state_nxt = ST_BLANK;
    endcase
  end

  // Output logic: the nibble is latched only when a slot opens, so
  // mid-slot data changes wait for that digit's next slot.
  always_comb begin
    w_timer_nxt  = w_timer_done ? '0 : r_timer + TW'(1);
    w_idx_nxt    = r_idx;
    w_nibble_nxt = r_nibble;
    w_en_n_nxt   = r_en_n;
    case (r_state)
      ST_BLANK: begin
        if (w_timer_done) begin
          w_nibble_nxt = w_sel_nibble;
          w_en_n_nxt   = w_lz_blank ? EN_OFF : digit_on_n(r_idx);
        end
      end
      ST_SCAN: begin
        if (w_timer_done) begin
          w_en_n_nxt = EN_OFF;
          w_idx_nxt  = r_idx + 2'd1;
        end
      end
      default: begin
        w_en_n_nxt = EN_OFF;
      end
    endcase
  end

  assign bus.nibble_out    = r_nibble;
  assign bus.digit_en_n    = r_en_n;
  assign bus.byte_cnt      = w_byte_cnt;
  assign bus.dbg_state     = r_state;
  assign bus.dbg_digit_idx = r_idx;

endmodule

// File: tb/tb_tx_hex_display_scanner.sv
// Directed bench for tx_hex_display_scanner with REFRESH_DIV=8, BLANK_CYCLES=2:
// expected digit slots are queued as bytes are driven and checked as slots open.
module tb_tx_hex_display_scanner;
  import tx_disp_pkg::*;

  localparam int RDIV  = 8;
  localparam int BLANK = 2;
  localparam int SLOT  = RDIV + BLANK;

  logic clk;
  logic rst;
  int   cyc;
  int   total;
  int   passed;
  logic [7:0] exp_cnt;
  logic [7:0] exp_q[$];

  tx_hex_display_scanner_if bus ();

  tx_hex_display_scanner #(
    .REFRESH_DIV  (RDIV),
    .BLANK_CYCLES (BLANK)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  function automatic logic [3:0] exp_en(input int d, input logic [7:0] cnt);
    logic [3:0] one;
    one = 4'b0001;
`ifdef TX_DISP_LZB_EN
    if (d == 3 && cnt[7:4] == 4'h0) return 4'b1111;
`endif
    return ~(one << d);
  endfunction

  task automatic do_reset();
    rst = 1'b1;
    bus.byte_valid = 1'b0;
    bus.cnt_clr = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    cyc = 0;
    exp_cnt = 8'h00;
  endtask

  // Driver tasks
  task automatic send_byte(input logic [7:0] b, input logic clr);
    bus.byte_valid = 1'b1;
    bus.byte_in = b;
    bus.cnt_clr = clr;
    tick();
    bus.byte_valid = 1'b0;
    bus.cnt_clr = 1'b0;
    exp_cnt = clr ? 8'h00 : exp_cnt + 8'h01;
  endtask

  task automatic sb_push(input int d, input logic [3:0] nib);
    exp_q.push_back({exp_en(d, exp_cnt), nib});
  endtask

  // Advance to the first lit cycle of digit d's slot, then pop and compare.
  task automatic wait_slot(input int d, input string tag);
    int n;
    logic [7:0] e;
    n = 0;
    do begin
      tick();
      n++;
    end while (!((cyc % SLOT) == BLANK && ((cyc / SLOT) % 4) == d) && n < 4 * SLOT + 2);
    if (n >= 4 * SLOT + 2) begin
      chk({tag, "_slot_timeout"}, 32'(n), 32'(4 * SLOT));
    end else if (exp_q.size() == 0) begin
      chk({tag, "_queue_empty"}, 32'(0), 32'(1));
    end else begin
      e = exp_q.pop_front();
      chk({tag, "_en"}, 32'(bus.digit_en_n), 32'(e[7:4]));
      chk({tag, "_nib"}, 32'(bus.nibble_out), 32'(e[3:0]));
    end
  endtask

  initial begin
    total = 0;
    passed = 0;
    cyc = 0;
    bus.byte_in = 8'h00;
    do_reset();

    // Reset state
    chk("rst_en", 32'(bus.digit_en_n), 32'hF);
    chk("rst_nib", 32'(bus.nibble_out), 32'h0);
    chk("rst_cnt", 32'(bus.byte_cnt), 32'h0);
    chk("rst_state", 32'(bus.dbg_state), 32'(ST_BLANK));
    chk("rst_idx", 32'(bus.dbg_digit_idx), 32'h0);

    // 1: scan timing over a full frame plus the start of the next
    for (int i = 0; i < 4 * SLOT + 4; i++) begin
      tick();
      if ((cyc % SLOT) < BLANK)
        chk($sformatf("t1_en_c%0d", cyc), 32'(bus.digit_en_n), 32'hF);
      else
        chk($sformatf("t1_en_c%0d", cyc), 32'(bus.digit_en_n),
            32'(exp_en((cyc / SLOT) % 4, 8'h00)));
      chk($sformatf("t1_nib_c%0d", cyc), 32'(bus.nibble_out), 32'h0);
    end

    // 2: one byte then a frame of digits
    do_reset();
    send_byte(8'hA7, 1'b0);
    chk("t2_cnt", 32'(bus.byte_cnt), 32'h01);
    sb_push(0, 4'h7);
    sb_push(1, 4'hA);
    sb_push(2, 4'h1);
    sb_push(3, 4'h0);
    wait_slot(0, "t2_d0");
    wait_slot(1, "t2_d1");
    wait_slot(2, "t2_d2");
    wait_slot(3, "t2_d3");

    // 3: counter wrap
    do_reset();
    for (int i = 0; i < 256; i++) send_byte(8'($urandom_range(0, 255)), 1'b0);
    chk("t3_wrap", 32'(bus.byte_cnt), 32'h00);
    send_byte(8'h5A, 1'b0);
    chk("t3_after_wrap", 32'(bus.byte_cnt), 32'h01);
    sb_push(3, 4'h0);
    wait_slot(3, "t3_d3");

    // 4: clear wins over a simultaneous strobe
    do_reset();
    for (int i = 0; i < 5; i++) send_byte(8'($urandom_range(0, 255)), 1'b0);
    chk("t4_cnt5", 32'(bus.byte_cnt), 32'h05);
    send_byte(8'h3C, 1'b1);
    chk("t4_clr", 32'(bus.byte_cnt), 32'h00);
    sb_push(0, 4'hC);
    sb_push(1, 4'h3);
    sb_push(2, 4'h0);
    wait_slot(0, "t4_d0");
    wait_slot(1, "t4_d1");
    wait_slot(2, "t4_d2");

    // 5: mid-slot update holds the lit nibble; reset mid-slot
    do_reset();
    send_byte(8'h12, 1'b0);
    sb_push(0, 4'h2);
    wait_slot(0, "t5_d0a");
    send_byte(8'h5F, 1'b0);
    chk("t5_hold_nib", 32'(bus.nibble_out), 32'h2);
    chk("t5_hold_en", 32'(bus.digit_en_n), 32'hE);
    sb_push(1, 4'h5);
    sb_push(0, 4'hF);
    wait_slot(1, "t5_d1");
    wait_slot(0, "t5_d0b");
    tick();
    tick();
    rst = 1'b1;
    tick();
    chk("t5_rst_en", 32'(bus.digit_en_n), 32'hF);
    chk("t5_rst_idx", 32'(bus.dbg_digit_idx), 32'h0);
    rst = 1'b0;
    cyc = 0;
    exp_cnt = 8'h00;
    tick();
    chk("t5_rst_blank", 32'(bus.digit_en_n), 32'hF);
    sb_push(0, 4'h0);
    wait_slot(0, "t5_restart");

    // 6: count MSD zero vs nonzero (blanked only with leading-zero blanking)
    do_reset();
    for (int i = 0; i < 9; i++) send_byte(8'($urandom_range(0, 255)), 1'b0);
    chk("t6_cnt9", 32'(bus.byte_cnt), 32'h09);
    sb_push(3, 4'h0);
    wait_slot(3, "t6_d3_zero");
    for (int i = 0; i < 7; i++) send_byte(8'($urandom_range(0, 255)), 1'b0);
    chk("t6_cnt10", 32'(bus.byte_cnt), 32'h10);
    sb_push(3, 4'h1);
    wait_slot(3, "t6_d3_one");

    chk("sb_drained", 32'(exp_q.size()), 32'h0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
